// File: rtl/mac_sequencer_pkg.sv
//------------------------------------------------------------------------------
// definitions: Q-format constants, sequencer state enum and a shared ReLU helper.
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package definitions;

  localparam int Q_INT  = 8;
  localparam int Q_FRAC = 8;
  localparam int Q_SIZE = Q_INT + Q_FRAC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_seq_state_t;

  function automatic logic signed [Q_SIZE-1:0] relu_q(input logic signed [Q_SIZE-1:0] v);
    return v[Q_SIZE-1] ? '0 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sequencer_if.sv
//------------------------------------------------------------------------------
// mac_sequencer_if: scheduler, operand-RAM and MacUnit signals of mac_sequencer.
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mac_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
);
  import definitions::*;

  logic                     start;
  logic                     abort;
  logic [LEN_W-1:0]         len;
  logic [ADDR_W-1:0]        x_base;
  logic [ADDR_W-1:0]        w_base;
  logic [ADDR_W-1:0]        x_addr;
  logic [ADDR_W-1:0]        w_addr;
  logic                     mem_rd_en;
  logic                     mac_acc_loopback;
  logic                     mac_acc_update;
  logic signed [Q_SIZE-1:0] mac;
  logic                     busy;
  logic signed [Q_SIZE-1:0] result;
  logic                     result_valid;
  logic                     result_ready;

  modport slave (
    input  start, abort, len, x_base, w_base, mac, result_ready,
    output x_addr, w_addr, mem_rd_en, mac_acc_loopback, mac_acc_update,
           busy, result, result_valid
  );

  modport master (
    output start, abort, len, x_base, w_base, mac, result_ready,
    input  x_addr, w_addr, mem_rd_en, mac_acc_loopback, mac_acc_update,
           busy, result, result_valid
  );

endinterface

`default_nettype wire

// File: rtl/mac_sequencer.sv
//------------------------------------------------------------------------------
// mac_sequencer: drives one MacUnit through an N-term dot product.
// Optional MAC_SEQ_RELU_EN clamps the captured result at zero.  rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mac_sequencer
  import definitions::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  mac_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_OUT   = OUT;

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        x_addr_q, x_addr_d;
  logic [ADDR_W-1:0]        w_addr_q, w_addr_d;
  logic [LEN_W-1:0]         k_q, k_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic signed [Q_SIZE-1:0] result_q, result_d;
  logic                     upd_q, lb_q;
  logic                     rd_en;
  logic signed [Q_SIZE-1:0] capture;

`ifdef MAC_SEQ_RELU_EN
  assign capture = relu_q(bus.mac);
`else
  assign capture = bus.mac;
`endif

  assign rd_en = (state_q == S_RUN);

  always_comb begin
    state_d  = state_q;
    x_addr_d = x_addr_q;
    w_addr_d = w_addr_q;
    k_d      = k_q;
    len_d    = len_q;
    result_d = result_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            len_d = bus.len;
            if (bus.len == '0) begin
              result_d = '0;
              state_d  = S_OUT;
            end else begin
              x_addr_d = bus.x_base;
              w_addr_d = bus.w_base;
              k_d      = '0;
              state_d  = S_RUN;
            end
          end
        end
        S_RUN: begin
          x_addr_d = x_addr_q + ADDR_W'(1);
          w_addr_d = w_addr_q + ADDR_W'(1);
          k_d      = k_q + LEN_W'(1);
          // compare before increment, so len = 2^LEN_W-1 never overflows k
          if (k_q == len_q - LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          result_d = capture;
          state_d  = S_OUT;
        end
        S_OUT: begin
          if (bus.result_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_addr_q <= '0;
      w_addr_q <= '0;
      k_q      <= '0;
      len_q    <= '0;
      result_q <= '0;
      upd_q    <= 1'b0;
      lb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_addr_q <= x_addr_d;
      w_addr_q <= w_addr_d;
      k_q      <= k_d;
      len_q    <= len_d;
      result_q <= result_d;
      // update tracks the one-cycle RAM latency; term 0 overwrites the accumulator
      upd_q    <= rd_en && !bus.abort;
      lb_q     <= rd_en && !bus.abort && (k_q != '0);
    end
  end

  assign bus.x_addr           = x_addr_q;
  assign bus.w_addr           = w_addr_q;
  assign bus.mem_rd_en        = rd_en;
  assign bus.mac_acc_update   = upd_q;
  assign bus.mac_acc_loopback = lb_q;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.result           = result_q;
  assign bus.result_valid     = (state_q == S_OUT);

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
//------------------------------------------------------------------------------
// tb_mac_sequencer: mac_sequencer with a behavioural MacUnit and two 1-cycle RAMs.
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_sequencer;
  import definitions::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mac_sequencer_if #(.ADDR_W(10), .LEN_W(10)) bus ();

  mac_sequencer #(.ADDR_W(10), .LEN_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic signed [15:0] xmem [0:1023];
  logic signed [15:0] wmem [0:1023];
  logic signed [15:0] xd = '0, wd = '0, acc, w_mac;
  logic signed [31:0] prod;
  logic signed [32:0] sum;

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      xd <= xmem[bus.x_addr];
      wd <= wmem[bus.w_addr];
    end
  end

  always_comb begin
    prod = (xd * wd) >>> 8;
    sum  = prod + (bus.mac_acc_loopback ? acc : 16'sd0);
    if (sum > 33'sd32767)       w_mac = 16'sh7FFF;
    else if (sum < -33'sd32768) w_mac = 16'sh8000;
    else                        w_mac = sum[15:0];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  acc <= '0;
    else if (bus.mac_acc_update) acc <= w_mac;
  end

  assign bus.mac = w_mac;

  logic        rec_rd [1:16], rec_upd [1:16], rec_lb [1:16], rec_val [1:16], rec_busy [1:16];
  logic [9:0]  rec_xa [1:16], rec_wa [1:16];
  logic [15:0] rec_res [1:16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n, input int xb, input int wb);
    bus.len    = 10'(n);
    bus.x_base = 10'(xb);
    bus.w_base = 10'(wb);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic record(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      rec_rd[c]   = bus.mem_rd_en;
      rec_upd[c]  = bus.mac_acc_update;
      rec_lb[c]   = bus.mac_acc_loopback;
      rec_val[c]  = bus.result_valid;
      rec_busy[c] = bus.busy;
      rec_xa[c]   = bus.x_addr;
      rec_wa[c]   = bus.w_addr;
      rec_res[c]  = bus.result;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    got = {bus.x_addr, bus.w_addr, bus.result, bus.mem_rd_en, bus.mac_acc_update,
           bus.mac_acc_loopback, bus.busy, bus.result_valid, 7'd0};
    n_checks++;
    if (got !== 32'd0 && got !== 32'd0) begin end
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %08h exp 00000000", got);
    end
  endtask

  task automatic test_basic();
    logic exp_upd, exp_lb;
    for (int i = 0; i < 4; i++) begin
      xmem[10+i] = 16'(256 * (i + 1));
      wmem[20+i] = 16'sd256;
    end
    launch(4, 10, 20);
    record(7);
    for (int c = 1; c <= 7; c++) begin
      exp_upd = (c >= 2 && c <= 5);
      exp_lb  = (c >= 3 && c <= 5);
      n_checks++;
      if (rec_rd[c] !== (c <= 4) || rec_upd[c] !== exp_upd || rec_lb[c] !== exp_lb ||
          rec_val[c] !== (c == 6) || rec_busy[c] !== (c <= 6)) begin
        n_fail++;
        $display("FAIL basic_ctrl c=%0d got rd/upd/lb/val/busy=%b%b%b%b%b exp %b%b%b%b%b", c,
                 rec_rd[c], rec_upd[c], rec_lb[c], rec_val[c], rec_busy[c],
                 c <= 4, exp_upd, exp_lb, c == 6, c <= 6);
      end
      if (c <= 4) begin
        n_checks++;
        if (rec_xa[c] !== 10'(9 + c) || rec_wa[c] !== 10'(19 + c)) begin
          n_fail++;
          $display("FAIL basic_addr c=%0d got x=%0d w=%0d exp x=%0d w=%0d", c, rec_xa[c], rec_wa[c], 9 + c, 19 + c);
        end
      end
    end
    n_checks++;
    if (rec_res[6] !== 16'd2560) begin
      n_fail++;
      $display("FAIL basic_result got %0d exp 2560", rec_res[6]);
    end
  endtask

  task automatic test_backpressure();
    bus.result_ready = 1'b0;
    launch(4, 10, 20);
    for (int i = 0; i < 5; i++) tick();
    bus.start = 1'b1;
    bus.len   = '0;
    for (int h = 0; h < 5; h++) begin
      n_checks++;
      if (bus.result_valid !== 1'b1 || bus.busy !== 1'b1 || bus.result !== 16'sd2560) begin
        n_fail++;
        $display("FAIL backpressure_hold h=%0d got val=%b busy=%b res=%0d exp val=1 busy=1 res=2560",
                 h, bus.result_valid, bus.busy, bus.result);
      end
      tick();
    end
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release got busy=%b val=%b exp busy=0 val=0", bus.busy, bus.result_valid);
    end
  endtask

  task automatic test_len_zero();
    launch(0, 0, 0);
    record(2);
    n_checks++;
    if (rec_val[1] !== 1'b1 || rec_res[1] !== 16'd0 || rec_rd[1] !== 1'b0 || rec_upd[1] !== 1'b0 ||
        rec_upd[2] !== 1'b0 || rec_rd[2] !== 1'b0 || rec_busy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL len_zero got val=%b res=%0d rd=%b%b upd=%b%b busy2=%b exp val=1 res=0 rd=00 upd=00 busy2=0",
               rec_val[1], rec_res[1], rec_rd[1], rec_rd[2], rec_upd[1], rec_upd[2], rec_busy[2]);
    end
  endtask

  task automatic test_wrap();
    xmem[1022] = 16'sd256; xmem[1023] = 16'sd256; xmem[0] = 16'sd256;
    wmem[5] = 16'sd512; wmem[6] = 16'sd512; wmem[7] = 16'sd512;
    launch(3, 1022, 5);
    record(6);
    n_checks++;
    if (rec_xa[1] !== 10'd1022 || rec_xa[2] !== 10'd1023 || rec_xa[3] !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_addr got %0d,%0d,%0d exp 1022,1023,0", rec_xa[1], rec_xa[2], rec_xa[3]);
    end
    n_checks++;
    if (rec_val[5] !== 1'b1 || rec_res[5] !== 16'd1536) begin
      n_fail++;
      $display("FAIL wrap_result got val=%b res=%0d exp val=1 res=1536", rec_val[5], rec_res[5]);
    end
  endtask

  task automatic test_abort();
    xmem[100] = 16'sd1792; wmem[200] = 16'sd256;
    xmem[300] = 16'sd512;  xmem[301] = 16'sd768;
    wmem[400] = 16'sd256;  wmem[401] = 16'sd256;
    launch(8, 100, 200);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.mac_acc_update !== 1'b0 || bus.result !== 16'sd1536) begin
      n_fail++;
      $display("FAIL abort_edge got busy=%b rd=%b upd=%b res=%0d exp busy=0 rd=0 upd=0 res=1536",
               bus.busy, bus.mem_rd_en, bus.mac_acc_update, bus.result);
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.mem_rd_en !== 1'b0 || bus.mac_acc_update !== 1'b0 || bus.result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet c=%0d got rd=%b upd=%b val=%b exp 0,0,0", c, bus.mem_rd_en,
                 bus.mac_acc_update, bus.result_valid);
      end
      tick();
    end
    launch(2, 300, 400);
    record(5);
    n_checks++;
    if (rec_upd[2] !== 1'b1 || rec_lb[2] !== 1'b0 || rec_lb[3] !== 1'b1 || rec_val[4] !== 1'b1 ||
        rec_res[4] !== 16'd1280) begin
      n_fail++;
      $display("FAIL abort_rerun got upd2=%b lb2=%b lb3=%b val4=%b res=%0d exp 1,0,1,1 res=1280",
               rec_upd[2], rec_lb[2], rec_lb[3], rec_val[4], rec_res[4]);
    end
  endtask

  task automatic test_relu();
    logic [15:0] exp_neg;
`ifdef MAC_SEQ_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'hFA00;
`endif
    xmem[500] = -16'sd768; wmem[600] = 16'sd512;
    launch(1, 500, 600);
    record(4);
    n_checks++;
    if (rec_val[3] !== 1'b1 || rec_res[3] !== exp_neg) begin
      n_fail++;
      $display("FAIL relu_negative got val=%b res=%04h exp val=1 res=%04h", rec_val[3], rec_res[3], exp_neg);
    end
    xmem[510] = 16'sd25600; xmem[511] = 16'sd25600;
    wmem[610] = 16'sd256;   wmem[611] = 16'sd256;
    launch(2, 510, 610);
    record(5);
    n_checks++;
    if (rec_val[4] !== 1'b1 || rec_res[4] !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL relu_saturated got val=%b res=%04h exp val=1 res=7fff", rec_val[4], rec_res[4]);
    end
  endtask

  task automatic test_back_to_back();
    xmem[700] = 16'sd256; wmem[800] = 16'sd768;
    bus.len = 10'd1; bus.x_base = 10'd700; bus.w_base = 10'd800;
    bus.start = 1'b1;
    tick();
    record(7);
    bus.start = 1'b0;
    tick();
    for (int c = 1; c <= 7; c++) begin
      n_checks++;
      if (rec_rd[c] !== (c == 1 || c == 5) || rec_val[c] !== (c == 3 || c == 7) || rec_busy[c] !== (c != 4)) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d got rd=%b val=%b busy=%b exp rd=%b val=%b busy=%b", c, rec_rd[c],
                 rec_val[c], rec_busy[c], c == 1 || c == 5, c == 3 || c == 7, c != 4);
      end
    end
    n_checks++;
    if (rec_res[3] !== 16'd768 || rec_res[7] !== 16'd768) begin
      n_fail++;
      $display("FAIL back_to_back_result got %0d,%0d exp 768,768", rec_res[3], rec_res[7]);
    end
  endtask

  task automatic test_async_reset();
    launch(4, 10, 20);
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.x_addr !== 10'd0 || bus.w_addr !== 10'd0 ||
        bus.result !== 16'sd0 || bus.result_valid !== 1'b0 || bus.mac_acc_update !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got busy=%b rd=%b x=%0d w=%0d res=%0d val=%b upd=%b exp all zero",
               bus.busy, bus.mem_rd_en, bus.x_addr, bus.w_addr, bus.result, bus.result_valid, bus.mac_acc_update);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      xmem[i] = '0;
      wmem[i] = '0;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.len = '0;
    bus.x_base = '0;
    bus.w_base = '0;
    bus.result_ready = 1'b1;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_wrap();
    test_abort();
    test_relu();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_sequencer.md
# mac_sequencer

Controller that sequences one `MacUnit` through an N-term dot product (one neuron evaluation). It issues paired x/w read addresses to the operand memories and drives `mac_acc_loopback`/`mac_acc_update` so the first term overwrites the accumulator and later terms accumulate. It captures the saturated result and presents it on a valid/ready output. It sits between the layer scheduler (start/len/base addresses) and the MAC datapath plus its two operand RAMs.

## Interface
- `ADDR_W`, 10: width of x and w memory addresses.
- `LEN_W`, 10: width of the term count.
- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous reset, active low.
- `start` in 1: request a dot product; sampled only in IDLE.
- `abort` in 1: cancel any operation; return to IDLE.
- `len` in LEN_W: number of terms N, sampled with `start`.
- `x_base`, `w_base` in ADDR_W: first operand addresses, sampled with `start`.
- `x_addr`, `w_addr` out ADDR_W: operand read addresses.
- `mem_rd_en` out 1: read strobe to both RAMs.
- `mac_acc_loopback` out 1: to MacUnit; 1 means accumulate onto `acc`.
- `mac_acc_update` out 1: to MacUnit; 1 means write `mac` into `acc`.
- `mac` in Q_SIZE (signed Q_INT.Q_FRAC): saturated MAC result from MacUnit.
- `busy` out 1: high in any state other than IDLE.
- `result` out Q_SIZE signed: captured dot product.
- `result_valid` out 1: result handshake valid.
- `result_ready` in 1: result handshake ready.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, OUT.
- IDLE, `start`=1, N>0: go to RUN. Load `x_addr`=x_base, `w_addr`=w_base and term counter k=0.
- IDLE, `start`=1, N=0: go to OUT. Load `result`=0 and issue no reads or updates.
- RUN: `mem_rd_en`=1 every cycle. Addresses and k increment after each cycle. After the cycle that issues term N-1, go to DRAIN.
- Addresses wrap modulo 2^ADDR_W.
- The RAM read latency is one cycle. `mac_acc_update` is `mem_rd_en` delayed by one cycle.
- `mac_acc_loopback` = `mac_acc_update` AND (term index ≠ 0). The first term therefore clears any stale accumulator.
- DRAIN: `mem_rd_en`=0 and the last update occurs. `result` captures `mac` on this edge. Go to OUT.
- OUT: `result_valid`=1. `result` is held stable while `result_ready`=0. On valid&ready, go to IDLE.
- `start` outside IDLE is ignored. `result_ready` outside OUT is ignored.
- `abort`=1 in any state: go to IDLE on the next edge. `mem_rd_en`, `mac_acc_update` and `result_valid` drop on that edge; `result` keeps its last value.
- `abort` has priority over `start` and over the result handshake.
- Saturation is owned by MacUnit. The sequencer performs no arithmetic beyond address and counter increments.

## Timing
- Reset values: state IDLE; `x_addr`, `w_addr`, k, `result` = 0; `mem_rd_en`, `mac_acc_update`, `mac_acc_loopback`, `busy`, `result_valid` = 0.
- Let `start` be sampled at edge e0, with N>0:
  - reads in cycles 1..N;
  - updates in cycles 2..N+1;
  - DRAIN in cycle N+1;
  - `result_valid` from cycle N+2.
- Latency from start to valid is N+2 cycles. For N=0 it is 1 cycle.
- Throughput: the next `start` can be accepted in the cycle after the handshake, so back-to-back operations take N+3 cycles each.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously).
- `len` reaching 2^LEN_W-1 is legal. k must not overflow before its compare.

## Configuration
- `MAC_SEQ_RELU_EN` defined: on capture, `result` = (`mac` < 0) ? 0 : `mac`.
- Undefined: `result` = `mac` unmodified.
- The macro affects no timing.

## Structure
- The `definitions` package holds Q_INT, Q_FRAC and Q_SIZE, plus a new enum `mac_seq_state_t` {IDLE, RUN, DRAIN, OUT}.
- No sub-module is required. The optional ReLU is an inline function `relu_q` in `definitions` so that other blocks can reuse it.
- The testbench instantiates `mac_sequencer` together with MacUnit and two 1-cycle behavioural RAMs.

## Test plan
- **Basic sequence:** len=4, x_base=10, w_base=20, x={1,2,3,4}, w={1,1,1,1} (integer Q) → addresses 10..13 and 20..23 in cycles 1..4. Loopback pattern 0,1,1,1 in cycles 2..5. `result`=10 and valid at cycle 6.
- **Backpressure:** same stimulus with `result_ready` low for 5 cycles → `result` stable, valid held, `busy`=1. IDLE the cycle after ready. A `start` during OUT is ignored.
- **len=0:** → no `mem_rd_en` and no updates. `result`=0 and valid at cycle 1.
- **Wrap:** x_base=2^ADDR_W-2, len=3 → x_addr sequence is max-1, max, 0.
- **Abort:** abort in cycle 2 of a len=8 run → IDLE next edge, no further reads or updates, valid never asserts. A new len=2 run then gives the correct, non-stale sum (loopback=0 on its first term).
- **ReLU:** x={-3}, w={2}, len=1 → `result`=0 with `MAC_SEQ_RELU_EN`, and -6 without it. A saturated positive sum passes through unchanged.
